// File: rtl/pixel_readout_buffer_if.sv
// Pixel stream from the readout buffer to the host-side sink.
// One pixel per beat, transferred on valid & ready.
interface pixel_readout_buffer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] o_Pixel_data;
    logic                  o_Pixel_valid;
    logic [1:0]            o_Pixel_index;
    logic                  o_Frame_last;
    logic                  i_Pixel_ready;

    modport master (
        output o_Pixel_data,
        output o_Pixel_valid,
        output o_Pixel_index,
        output o_Frame_last,
        input  i_Pixel_ready
    );

    modport slave (
        input  o_Pixel_data,
        input  o_Pixel_valid,
        input  o_Pixel_index,
        input  o_Frame_last,
        output i_Pixel_ready
    );
endinterface

// File: rtl/pixel_readout_buffer.sv
// Captures two-column ADC rows into a ping-pong 2x2 frame buffer
// and streams completed frames one pixel per beat.
module pixel_readout_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_NRE_1,
    input  logic                    i_NRE_2,
    input  logic                    i_ADC,
    input  logic                    i_Erase,
    input  logic [2*DATA_WIDTH-1:0] i_ADC_data,
    pixel_readout_buffer_if.master  pix,
    output logic [7:0]              o_Frame_count,
    output logic                    o_Overrun,
    output logic                    o_Seq_error
);

    typedef enum logic [1:0] {
        WAIT_R1 = 2'd0,
        WAIT_R2 = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic r_adc_d;
    logic w_strobe;
    logic w_row1;
    logic w_row2;
    logic w_bad;

    logic [DATA_WIDTH-1:0] r_mem [2][4];
    logic [1:0]            r_full;
    logic [1:0]            w_full_nxt;
    logic                  r_wptr;
    logic                  r_rptr;
    logic                  w_rnext;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_index;
    logic                  r_last;
    logic [7:0]            r_frame_count;
    logic                  r_overrun;
    logic                  r_seq_error;

    logic w_xfer;
    logic w_last_xfer;
    logic w_free;
    logic w_wr_r1;
    logic w_commit;
    logic w_ovr;
    logic w_seq;

    assign w_strobe = i_ADC & ~r_adc_d;
    assign w_row1   = w_strobe & ~i_NRE_1 & i_NRE_2;
    assign w_row2   = w_strobe & i_NRE_1 & ~i_NRE_2;
    assign w_bad    = w_strobe & (i_NRE_1 == i_NRE_2);

    assign w_xfer      = r_valid & pix.i_Pixel_ready;
    assign w_last_xfer = w_xfer & r_last;
    assign w_rnext     = ~r_rptr;

    // A bank finishing its last beat this cycle counts as free.
    assign w_free = ~r_full[r_wptr]
                  | (w_last_xfer & (r_wptr == r_rptr));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= WAIT_R1;
            r_adc_d <= 1'b0;
        end else begin
            r_state <= w_next;
            r_adc_d <= i_ADC;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_wr_r1  = 1'b0;
        w_commit = 1'b0;
        w_ovr    = 1'b0;
        w_seq    = 1'b0;
        if (i_Erase) begin
            w_next = WAIT_R1;
        end else if (w_bad) begin
            w_seq = 1'b1;
        end else begin
            case (r_state)
                WAIT_R1: begin
                    if (w_row1) begin
                        if (w_free) begin
                            w_wr_r1 = 1'b1;
                            w_next  = WAIT_R2;
                        end else begin
                            w_ovr  = 1'b1;
                            w_next = DROP;
                        end
                    end else if (w_row2) begin
                        w_seq = 1'b1;
                    end
                end
                WAIT_R2: begin
                    if (w_row1) begin
                        w_wr_r1 = 1'b1;
                    end else if (w_row2) begin
                        w_commit = 1'b1;
                        w_next   = WAIT_R1;
                    end
                end
                DROP: begin
                    if (w_row2) begin
                        w_next = WAIT_R1;
                    end
                end
                default: w_next = WAIT_R1;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_wr_r1) begin
            r_mem[r_wptr][0] <= i_ADC_data[DATA_WIDTH-1:0];
            r_mem[r_wptr][1] <= i_ADC_data[2*DATA_WIDTH-1:DATA_WIDTH];
        end
        if (w_commit) begin
            r_mem[r_wptr][2] <= i_ADC_data[DATA_WIDTH-1:0];
            r_mem[r_wptr][3] <= i_ADC_data[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    always_comb begin
        w_full_nxt = r_full;
        if (w_last_xfer) begin
            w_full_nxt[r_rptr] = 1'b0;
        end
        if (w_commit) begin
            w_full_nxt[r_wptr] = 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_full        <= 2'b00;
            r_wptr        <= 1'b0;
            r_frame_count <= 8'd0;
            r_overrun     <= 1'b0;
            r_seq_error   <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_commit) begin
                r_wptr        <= ~r_wptr;
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_ovr) begin
                r_overrun <= 1'b1;
            end
            if (w_seq) begin
                r_seq_error <= 1'b1;
            end
        end
    end

    // On the last beat the other bank is launched directly, so
    // back-to-back frames stream without a gap.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rptr  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= 2'd0;
            r_last  <= 1'b0;
        end else if (w_last_xfer) begin
            r_rptr  <= w_rnext;
            r_index <= 2'd0;
            r_last  <= 1'b0;
            r_valid <= r_full[w_rnext];
            if (r_full[w_rnext]) begin
                r_data <= r_mem[w_rnext][0];
            end
        end else if (w_xfer) begin
            r_index <= r_index + 2'd1;
            r_data  <= r_mem[r_rptr][r_index + 2'd1];
            r_last  <= (r_index == 2'd2);
        end else if (!r_valid && r_full[r_rptr]) begin
            r_valid <= 1'b1;
            r_data  <= r_mem[r_rptr][0];
            r_index <= 2'd0;
            r_last  <= 1'b0;
        end
    end

    assign pix.o_Pixel_valid = r_valid;
    assign pix.o_Pixel_data  = r_data;
    assign pix.o_Pixel_index = r_index;
    assign pix.o_Frame_last  = r_last;
    assign o_Frame_count     = r_frame_count;
    assign o_Overrun         = r_overrun;
    assign o_Seq_error       = r_seq_error;

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Scoreboard bench for pixel_readout_buffer: frame-level model,
// queue of expected beats, independent output monitor.
module tb_pixel_readout_buffer;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        nre1;
    logic        nre2;
    logic        adc;
    logic        erase;
    logic [15:0] adata;
    logic [7:0]  fcount;
    logic        ovr;
    logic        seqe;

    pixel_readout_buffer_if #(.DATA_WIDTH(DW)) pix ();

    pixel_readout_buffer #(.DATA_WIDTH(DW)) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_NRE_1      (nre1),
        .i_NRE_2      (nre2),
        .i_ADC        (adc),
        .i_Erase      (erase),
        .i_ADC_data   (adata),
        .pix          (pix),
        .o_Frame_count(fcount),
        .o_Overrun    (ovr),
        .o_Seq_error  (seqe)
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] i;
    } beat_t;

    beat_t       q[$];
    int          pending;
    int          m_st;
    logic [15:0] m_r1;
    logic        m_prev_adc;
    int          m_count;
    bit          m_ovr;
    bit          m_seq;
    int          n_tests;
    int          n_fail;
    int          beats_seen;
    bit          rdy;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pending    = 0;
        m_st       = 0;
        m_r1       = '0;
        m_prev_adc = 1'b0;
        m_count    = 0;
        m_ovr      = 1'b0;
        m_seq      = 1'b0;
    endtask

    // m_st: 0 = expecting row 1, 1 = row 1 held, 2 = dropping frame
    task automatic model_step();
        bit s;
        s = adc && !m_prev_adc;
        m_prev_adc = adc;
        if (erase) begin
            m_st = 0;
        end else if (s) begin
            if (nre1 == nre2) begin
                m_seq = 1'b1;
            end else if (!nre1) begin
                if (m_st == 0) begin
                    if (pending < 2) begin
                        m_r1 = adata;
                        m_st = 1;
                    end else begin
                        m_ovr = 1'b1;
                        m_st  = 2;
                    end
                end else if (m_st == 1) begin
                    m_r1 = adata;
                end
            end else begin
                if (m_st == 0) begin
                    m_seq = 1'b1;
                end else if (m_st == 1) begin
                    q.push_back('{m_r1[7:0], 2'd0});
                    q.push_back('{m_r1[15:8], 2'd1});
                    q.push_back('{adata[7:0], 2'd2});
                    q.push_back('{adata[15:8], 2'd3});
                    pending++;
                    m_count = (m_count + 1) % 256;
                    m_st = 0;
                end else begin
                    m_st = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic n1, input logic n2,
                         input logic a, input logic e,
                         input logic [15:0] d, input logic r);
        @(posedge clk);
        #2;
        rst   = r;
        nre1  = n1;
        nre2  = n2;
        adc   = a;
        erase = e;
        adata = d;
        pix.i_Pixel_ready = rdy;
        if (r) model_reset();
        @(negedge clk);
        #1;
        if (!r) model_step();
    endtask

    task automatic idle();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic strobe(input logic n1, input logic n2,
                          input logic [15:0] d);
        cycle(n1, n2, 1'b1, 1'b0, d, 1'b0);
        idle();
    endtask

    task automatic frame(input logic [15:0] d1, input logic [15:0] d2);
        strobe(1'b0, 1'b1, d1);
        strobe(1'b1, 1'b0, d2);
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while ((q.size() != 0 || pix.o_Pixel_valid) && k < maxc) begin
            idle();
            k++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic wait_idx(input logic [1:0] idx, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            if (pix.o_Pixel_valid && pix.o_Pixel_index == idx) begin
                ok = 1'b1;
                break;
            end
            idle();
        end
        chk("wait_idx", ok, 1);
    endtask

    bit         hold_v;
    logic [7:0] hold_d;
    logic [1:0] hold_i;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", pix.o_Pixel_valid, 1);
                chk("hold_data", pix.o_Pixel_data, hold_d);
                chk("hold_index", pix.o_Pixel_index, hold_i);
            end
            if (pix.o_Pixel_valid && pix.i_Pixel_ready) begin
                beats_seen++;
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat actual=%0h idx=%0d required=none",
                             pix.o_Pixel_data, pix.o_Pixel_index);
                end else begin
                    e = q.pop_front();
                    chk("beat_data", pix.o_Pixel_data, e.d);
                    chk("beat_index", pix.o_Pixel_index, e.i);
                    chk("beat_last", pix.o_Frame_last, e.i == 2'd3);
                    if (e.i == 2'd3) pending--;
                end
            end
            hold_v = pix.o_Pixel_valid && !pix.i_Pixel_ready;
            hold_d = pix.o_Pixel_data;
            hold_i = pix.o_Pixel_index;
        end
    end

    initial begin
        int op;
        int base;
        n_tests = 0;
        n_fail = 0;
        beats_seen = 0;
        hold_v = 1'b0;
        rst = 1'b1;
        nre1 = 1'b1;
        nre2 = 1'b1;
        adc = 1'b0;
        erase = 1'b0;
        adata = '0;
        rdy = 1'b0;
        pix.i_Pixel_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);

        idle();
        chk("rst_valid", pix.o_Pixel_valid, 0);
        chk("rst_data", pix.o_Pixel_data, 0);
        chk("rst_index", pix.o_Pixel_index, 0);
        chk("rst_last", pix.o_Frame_last, 0);
        chk("rst_count", fcount, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_seq", seqe, 0);

        rdy = 1'b1;
        strobe(1'b0, 1'b1, 16'h2211);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h4433, 1'b0);
        idle();
        chk("valid_at_capture", pix.o_Pixel_valid, 0);
        idle();
        chk("valid_after_capture", pix.o_Pixel_valid, 1);
        chk("first_data", pix.o_Pixel_data, 8'h11);
        drain(20);
        chk("count_single", fcount, 1);

        frame(16'h2211, 16'h4433);
        wait_idx(2'd1, 20);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("bp_data", pix.o_Pixel_data, 8'h33);
            chk("bp_index", pix.o_Pixel_index, 2);
        end
        rdy = 1'b1;
        drain(20);
        chk("count_bp", fcount, 2);

        rdy = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame(16'($urandom), 16'($urandom));
        end
        chk("ovr_set", ovr, 1);
        chk("ovr_count", fcount, 4);
        beats_seen = 0;
        rdy = 1'b1;
        drain(40);
        chk("ovr_beats", beats_seen, 8);

        strobe(1'b0, 1'b1, 16'h1111);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
        idle();
        frame(16'hBBAA, 16'hDDCC);
        drain(20);

        chk("seq_clear", seqe, 0);
        base = fcount;
        strobe(1'b0, 1'b0, 16'h5555);
        strobe(1'b1, 1'b0, 16'h6666);
        idle();
        chk("seq_set", seqe, 1);
        chk("seq_count", fcount, base);
        chk("seq_novalid", pix.o_Pixel_valid, 0);

        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h7788, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'($urandom), 1'b0);
        end
        idle();
        strobe(1'b1, 1'b0, 16'h99AA);
        drain(20);
        chk("held_adc_count", fcount, base + 1);

        frame(16'h0201, 16'h0403);
        wait_idx(2'd1, 20);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        idle();
        chk("mrst_valid", pix.o_Pixel_valid, 0);
        chk("mrst_data", pix.o_Pixel_data, 0);
        chk("mrst_index", pix.o_Pixel_index, 0);
        chk("mrst_last", pix.o_Frame_last, 0);
        chk("mrst_count", fcount, 0);
        chk("mrst_ovr", ovr, 0);
        chk("mrst_seq", seqe, 0);
        frame(16'hF0E0, 16'hD0C0);
        drain(20);
        chk("mrst_frame_count", fcount, 1);

        for (int s = 0; s < 400; s++) begin
            rdy = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 11);
            if (op <= 3) strobe(1'b0, 1'b1, 16'($urandom));
            else if (op <= 6) strobe(1'b1, 1'b0, 16'($urandom));
            else if (op == 7) strobe(1'b0, 1'b0, 16'($urandom));
            else if (op == 8) cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
            else if (op == 9) begin
                cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'($urandom), 1'b0);
                cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'($urandom), 1'b0);
                idle();
            end else idle();
        end
        rdy = 1'b1;
        drain(200);
        chk("rand_count", fcount, m_count);
        chk("rand_ovr", ovr, m_ovr);
        chk("rand_seq", seqe, m_seq);
        chk("rand_pending", pending, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pixel_readout_buffer.md
# pixel_readout_buffer

Downstream capture stage for the exposure controller. It watches the controller's row-enable strobes (i_NRE_1/i_NRE_2, active low), ADC strobe (i_ADC) and erase strobe (i_Erase), and samples the two-column ADC result for each row into a ping-pong 2x2 frame buffer. Completed frames are streamed out one pixel per beat over a valid/ready handshake. It sits between the exposure controller / ADC and the host-side pixel sink.

## Interface
- DATA_WIDTH, 8, bits per pixel sample.
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_NRE_1  in  1  row 1 enable from the exposure controller, active low.
- i_NRE_2  in  1  row 2 enable from the exposure controller, active low.
- i_ADC  in  1  ADC conversion strobe from the exposure controller.
- i_Erase  in  1  erase phase indicator from the exposure controller.
- i_ADC_data  in  2*DATA_WIDTH  ADC result; [DATA_WIDTH-1:0] = column 0, upper half = column 1.
- i_Pixel_ready  in  1  sink ready.
- o_Pixel_data  out  DATA_WIDTH  current pixel.
- o_Pixel_valid  out  1  pixel valid.
- o_Pixel_index  out  2  pixel position {row, col}: 0=r1c0, 1=r1c1, 2=r2c0, 3=r2c1.
- o_Frame_last  out  1  high with index 3 beat.
- o_Frame_count  out  8  committed frames, wraps 255->0.
- o_Overrun  out  1  sticky: frame dropped because both banks were full.
- o_Seq_error  out  1  sticky: illegal strobe/row combination.

## Operation
- Strobe detect: register i_ADC into adc_d. A strobe is i_ADC=1 and adc_d=0. Only strobes are acted on; a held-high i_ADC captures once.
- Row select on a strobe: i_NRE_1=0 and i_NRE_2=1 -> row 1; i_NRE_1=1 and i_NRE_2=0 -> row 2. Both low or both high -> strobe ignored, o_Seq_error set.
- Capture FSM, states WAIT_R1, WAIT_R2, DROP:
  - WAIT_R1: row-1 strobe with a free bank -> store both columns into row 1 of the write bank, go to WAIT_R2. Row-1 strobe with no free bank -> set o_Overrun, go to DROP. Row-2 strobe -> o_Seq_error, stay.
  - WAIT_R2: row-2 strobe -> store row 2, mark write bank full, toggle write bank pointer, increment o_Frame_count, go to WAIT_R1. Row-1 strobe -> overwrite row 1, stay.
  - DROP: row-2 strobe -> WAIT_R1; no data stored, count unchanged.
  - i_Erase=1 in any state -> WAIT_R1 next cycle, partial row-1 data discarded. Full banks are unaffected. Erase has priority over a coincident strobe.
- Read side: the read pointer bank streams when full. Beats go in order 0,1,2,3. A beat transfers on o_Pixel_valid & i_Pixel_ready. On the index-3 transfer the bank is freed, the read pointer toggles, and the index returns to 0.
- Valid/ready rules: while o_Pixel_valid=1 and i_Pixel_ready=0, o_Pixel_data, o_Pixel_index and o_Frame_last hold. o_Pixel_valid never drops without a transfer, except on reset.
- Simultaneous events: a bank freed (last beat) and a bank filled (row-2 commit) in the same cycle are both honoured; the full count is unchanged. A row-1 strobe in the same cycle as a last-beat transfer sees the freed bank as free (no overrun).
- Sticky flags clear only on i_Reset.

## Timing
- Reset: all outputs 0, both banks empty, pointers 0, FSM in WAIT_R1, adc_d=0.
- Capture: data is registered on the same edge that samples the strobe.
- Commit to valid: o_Pixel_valid rises on the first edge after the row-2 capture edge if the read side is idle. Otherwise it rises when the preceding frame's last beat transfers.
- Throughput: one pixel per cycle with i_Pixel_ready held high. A back-to-back second full bank streams with no gap cycle.
- o_Frame_count and o_Overrun update on the capture edge.
- Reset mid-stream: o_Pixel_valid goes to 0 on the next edge and buffered data is lost.

## Test plan
- Single frame: row 1 strobe with data 16'h2211, then row 2 strobe with 16'h4433, ready=1 -> beats 11,22,33,44 with index 0..3, last on 44, o_Frame_count=1, valid rises one cycle after row-2 capture.
- Backpressure: same frame with ready low for 3 cycles at beat 2 -> data 33 and index 2 held stable for 3 cycles, no beat lost or duplicated.
- Overrun: three frames committed with ready=0 -> first two stored, third row-1 strobe sets o_Overrun=1, o_Frame_count=2. Releasing ready yields exactly 8 beats from frames 1 and 2.
- Erase mid-frame: row 1 captured, then i_Erase pulse, then rows 1/2 with new data 16'hBBAA/16'hDDCC -> streamed frame is AA,BB,CC,DD.
- Sequence errors: strobe with both NRE low, and row-2 strobe in WAIT_R1 -> o_Seq_error=1, nothing stored, count unchanged. i_ADC held high for 5 cycles -> single capture.
- Reset mid-stream after beat 1 -> all outputs 0 next edge. A following clean frame streams normally with o_Frame_count=1.
